// File: rtl/button_conditioner.sv
// Player button front end: synchroniser, debouncer, edge pulses and
// hold auto-repeat for every button channel.
module button_conditioner #(
  parameter int NUM_BUTTONS = 5,
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int REPEAT_DELAY = 3600000,
  parameter int REPEAT_PERIOD = 1200000,
  parameter logic [NUM_BUTTONS-1:0] REPEAT_MASK = 5'b01111
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] btn_raw,
  output logic [NUM_BUTTONS-1:0] btn_level,
  output logic [NUM_BUTTONS-1:0] btn_press,
  output logic [NUM_BUTTONS-1:0] btn_release,
  output logic [NUM_BUTTONS-1:0] btn_repeat,
  output logic                   any_press
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                        REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RMAX);

  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } rstate_e;

  logic [NUM_BUTTONS-1:0] s1_q;
  logic [NUM_BUTTONS-1:0] s2_q;
  logic [NUM_BUTTONS-1:0] level_q;
  logic [NUM_BUTTONS-1:0] level_d;
  logic [NUM_BUTTONS-1:0] press_q;
  logic [NUM_BUTTONS-1:0] press_d;
  logic [NUM_BUTTONS-1:0] release_q;
  logic [NUM_BUTTONS-1:0] release_d;
  logic [NUM_BUTTONS-1:0] repeat_q;
  logic [NUM_BUTTONS-1:0] repeat_d;
  logic                   any_q;
  logic                   any_d;

  logic [DW-1:0] cnt_q  [NUM_BUTTONS];
  logic [DW-1:0] cnt_d  [NUM_BUTTONS];
  logic [RW-1:0] rcnt_q [NUM_BUTTONS];
  logic [RW-1:0] rcnt_d [NUM_BUTTONS];
  rstate_e       st_q   [NUM_BUTTONS];
  rstate_e       st_d   [NUM_BUTTONS];

  // Any sample equal to the level restarts the count, so short glitches vanish.
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != level_q[i]) begin
        if (cnt_q[i] == DB_LAST) begin
          level_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + DW'(1);
        end
      end
    end
    press_d = level_d & ~level_q;
    release_d = ~level_d & level_q;
    any_d = |press_d;
  end

  // Repeat timing starts on the level edge itself so the first
  // repeat lands exactly REPEAT_DELAY cycles after the press pulse.
  always_comb begin
    repeat_d = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      st_d[i] = st_q[i];
      rcnt_d[i] = rcnt_q[i];
      if (release_d[i]) begin
        st_d[i] = IDLE;
        rcnt_d[i] = '0;
      end else begin
        case (st_q[i])
          IDLE: begin
            if (press_d[i]) begin
              st_d[i] = DELAY;
              rcnt_d[i] = '0;
            end
          end
          DELAY: begin
            if (rcnt_q[i] == RD_LAST) begin
              repeat_d[i] = 1'b1;
              rcnt_d[i] = '0;
              st_d[i] = REPEAT;
            end else begin
              rcnt_d[i] = rcnt_q[i] + RW'(1);
            end
          end
          REPEAT: begin
            if (rcnt_q[i] == RP_LAST) begin
              repeat_d[i] = 1'b1;
              rcnt_d[i] = '0;
            end else begin
              rcnt_d[i] = rcnt_q[i] + RW'(1);
            end
          end
          default: begin
            st_d[i] = IDLE;
            rcnt_d[i] = '0;
          end
        endcase
      end
    end
    repeat_d = repeat_d & REPEAT_MASK;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q      <= '0;
      s2_q      <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      repeat_q  <= '0;
      any_q     <= 1'b0;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        cnt_q[i]  <= '0;
        rcnt_q[i] <= '0;
        st_q[i]   <= IDLE;
      end
    end else begin
      s1_q      <= btn_raw;
      s2_q      <= s1_q;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
      any_q     <= any_d;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        cnt_q[i]  <= cnt_d[i];
        rcnt_q[i] <= rcnt_d[i];
        st_q[i]   <= st_d[i];
      end
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_repeat  = repeat_q;
  assign any_press   = any_q;

endmodule
